sample_mem_loader: RTL and testbench
====================================

Name: sample_mem_loader

Overview:
- Writer side of the training-sample interface. Accepts a framed word stream (one label word, then INPUT_SIZE pixel words per sample) and fills the sample and label RAMs.
- The same RAMs are exposed on the synchronous read ports that neural_network_top consumes: sample_addr/sample_en/sample_rdata and label_addr/label_en/label_rdata, each with 1-cycle read latency.
- Sits between the host/DMA stream and neural_network_top. load_done gates the top-level start.

Parameters:
- INPUT_SIZE, 784, pixel words per sample
- NUM_SAMPLES, 100, samples per load
- DATA_WIDTH, 32, word width (Q16.16 pixels)
- NUM_CLASSES, 10, legal label values 0..NUM_CLASSES-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse: clear counters/flags, begin load
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts word
- in_data  in  DATA_WIDTH  label (bits[3:0]) or pixel word
- in_last  in  1  marks final pixel of a sample
- load_busy  out  1  load in progress
- load_done  out  1  all NUM_SAMPLES stored; held until next load_start/rst
- samples_loaded  out  $clog2(NUM_SAMPLES+1)  completed samples
- label_err  out  1  sticky: label >= NUM_CLASSES seen
- frame_err  out  1  sticky: in_last mismatch seen
- sample_addr  in  $clog2(NUM_SAMPLES*INPUT_SIZE)  read address
- sample_en  in  1  read enable
- sample_rdata  out  DATA_WIDTH  registered read data
- label_addr  in  $clog2(NUM_SAMPLES)  label read address
- label_en  in  1  label read enable
- label_rdata  out  4  registered label

Behaviour:
- Reset: state IDLE. in_ready, load_busy, load_done, label_err and frame_err are 0. samples_loaded=0, sample_rdata=0, label_rdata=0. RAM contents are not cleared.
- A transfer occurs on a cycle where in_valid && in_ready. in_ready is combinational from state only: 1 in LABEL and PIXEL, 0 in IDLE and DONE.
- States:
  - IDLE: load_start -> LABEL; clear samp_idx, pix_idx, samples_loaded, label_err, frame_err, load_done.
  - LABEL: on transfer, write label_mem[samp_idx] <= in_data[3:0]. Set label_err if in_data >= NUM_CLASSES; the low nibble is still stored. Then -> PIXEL, pix_idx=0.
  - PIXEL: on transfer, write sample_mem[samp_idx*INPUT_SIZE+pix_idx] <= in_data.
    - pix_idx < INPUT_SIZE-1 and in_last=0: pix_idx++.
    - pix_idx < INPUT_SIZE-1 and in_last=1: early end. Set frame_err, do not advance samp_idx, -> LABEL. The partial sample is overwritten by the next frame.
    - pix_idx == INPUT_SIZE-1: sample complete. If in_last=0, set frame_err. samp_idx++ and samples_loaded++. If samp_idx was NUM_SAMPLES-1 -> DONE, else -> LABEL.
  - DONE: load_done=1, load_busy=0. load_start -> LABEL, clearing as in IDLE.
- load_busy=1 exactly in LABEL and PIXEL.
- load_start while in LABEL/PIXEL restarts the load: counters and flags clear, -> LABEL, and a coincident stream word is discarded. load_start has priority over any transfer.
- The address is computed with a running base register (base += INPUT_SIZE per sample); no multiplier.
- Read ports are independent of load state and may be used at any time:
  - sample_rdata <= sample_mem[sample_addr] on the clk edge where sample_en=1; otherwise it holds.
  - label_rdata behaves the same with label_en.
  - Simultaneous read and write to the same address returns the old data (read-before-write).
- rst mid-load: returns to IDLE immediately. Words already written remain in RAM; samples_loaded reads 0.
- RAMs must infer block RAM: one write port and one registered read port each.

Test Plan:
- Use NUM_SAMPLES=4, INPUT_SIZE=8 throughout.
- Full load: load_start, stream 4 frames of label i, pixels 32'h100*i+k, in_last on k=7, in_valid held 1 -> load_done rises the cycle after the 36th transfer, samples_loaded=4, no error flags. Reading sample_addr=19 returns 32'h00000203 one cycle later; label_addr=2 returns 2.
- Backpressure/gaps: in_valid toggled randomly -> identical RAM contents. in_ready=0 in DONE; words offered then are ignored and RAM is unchanged.
- Early in_last on pixel 4 of sample 1 -> frame_err=1, samples_loaded stays 1. A resent full sample 1 lands at addresses 8..15, and loading ends with samples_loaded=4.
- Label 12 on sample 0 -> label_err=1, label_rdata at addr 0 returns 4'hC. Missing in_last on pixel 7 -> frame_err=1, load still advances.
- load_start during sample 2 -> counters and flags cleared, next word is treated as the label for sample 0. rst during PIXEL -> all outputs at reset values on the next cycle.
- Read/write collision: in the cycle the loader writes addr 5, a read of addr 5 returns the previous contents; a read on the following cycle returns the new word.

Source files
------------

// File: rtl/sample_mem_loader.sv
// sample_mem_loader: writer side of the training-sample store.
// Consumes a framed word stream (one label word followed by INPUT_SIZE pixel
// words per sample) and fills the label and sample RAMs. Both RAMs also have
// an independent registered read port for the network core.
module sample_mem_loader #(
   parameter int INPUT_SIZE  = 784,
   parameter int NUM_SAMPLES = 100,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_CLASSES = 10
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      load_start,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [DATA_WIDTH-1:0]                     in_data,
   input  logic                                      in_last,
   output logic                                      load_busy,
   output logic                                      load_done,
   output logic [$clog2(NUM_SAMPLES+1)-1:0]          samples_loaded,
   output logic                                      label_err,
   output logic                                      frame_err,
   input  logic [$clog2(NUM_SAMPLES*INPUT_SIZE)-1:0] sample_addr,
   input  logic                                      sample_en,
   output logic [DATA_WIDTH-1:0]                     sample_rdata,
   input  logic [$clog2(NUM_SAMPLES)-1:0]            label_addr,
   input  logic                                      label_en,
   output logic [3:0]                                label_rdata
);

   localparam int SAW   = $clog2(NUM_SAMPLES*INPUT_SIZE);
   localparam int LAW   = $clog2(NUM_SAMPLES);
   localparam int CW    = $clog2(NUM_SAMPLES+1);
   localparam int PW    = $clog2(INPUT_SIZE+1);
   localparam int DEPTH = NUM_SAMPLES*INPUT_SIZE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LABEL = 2'd1,
      PIXEL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_reg;
   logic [LAW-1:0]  samp_idx_reg;
   logic [PW-1:0]   pix_idx_reg;
   logic [SAW-1:0]  base_reg;
   logic [CW-1:0]   samples_loaded_reg;
   logic            label_err_reg;
   logic            frame_err_reg;
   logic            load_done_reg;
   logic            load_busy_reg;
   logic [DATA_WIDTH-1:0] sample_rdata_reg;
   logic [3:0]            label_rdata_reg;

   logic [DATA_WIDTH-1:0] sample_mem [0:DEPTH-1];
   logic [3:0]            label_mem  [0:NUM_SAMPLES-1];

   logic            xfer;
   logic            label_we;
   logic            sample_we;
   logic            pix_last;
   logic            samp_last;
   logic [SAW-1:0]  sample_waddr;

   // Handshake and write strobes; load_start and rst suppress any coincident word
   assign in_ready     = (state_reg == LABEL) || (state_reg == PIXEL);
   assign xfer         = in_valid && in_ready && !load_start && !rst;
   assign label_we     = xfer && (state_reg == LABEL);
   assign sample_we    = xfer && (state_reg == PIXEL);
   assign pix_last     = (pix_idx_reg == PW'(INPUT_SIZE-1));
   assign samp_last    = (samp_idx_reg == LAW'(NUM_SAMPLES-1));
   assign sample_waddr = base_reg + SAW'(pix_idx_reg);

   assign load_busy      = load_busy_reg;
   assign load_done      = load_done_reg;
   assign samples_loaded = samples_loaded_reg;
   assign label_err      = label_err_reg;
   assign frame_err      = frame_err_reg;
   assign sample_rdata   = sample_rdata_reg;
   assign label_rdata    = label_rdata_reg;

   // Load sequencer: walks label/pixel framing, tracks counters and sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= IDLE;
         samp_idx_reg       <= '0;
         pix_idx_reg        <= '0;
         base_reg           <= '0;
         samples_loaded_reg <= '0;
         label_err_reg      <= 1'b0;
         frame_err_reg      <= 1'b0;
         load_done_reg      <= 1'b0;
         load_busy_reg      <= 1'b0;
      end else if (load_start) begin
         state_reg          <= LABEL;
         samp_idx_reg       <= '0;
         pix_idx_reg        <= '0;
         base_reg           <= '0;
         samples_loaded_reg <= '0;
         label_err_reg      <= 1'b0;
         frame_err_reg      <= 1'b0;
         load_done_reg      <= 1'b0;
         load_busy_reg      <= 1'b1;
      end else begin
         case (state_reg)
            LABEL: begin
               if (xfer) begin
                  if (in_data >= DATA_WIDTH'(NUM_CLASSES)) label_err_reg <= 1'b1;
                  pix_idx_reg <= '0;
                  state_reg   <= PIXEL;
               end
            end
            PIXEL: begin
               if (xfer) begin
                  if (!pix_last) begin
                     if (in_last) begin
                        // Short frame: discard it, the next frame reuses this slot
                        frame_err_reg <= 1'b1;
                        pix_idx_reg   <= '0;
                        state_reg     <= LABEL;
                     end else begin
                        pix_idx_reg <= pix_idx_reg + PW'(1);
                     end
                  end else begin
                     if (!in_last) frame_err_reg <= 1'b1;
                     pix_idx_reg        <= '0;
                     samples_loaded_reg <= samples_loaded_reg + CW'(1);
                     if (samp_last) begin
                        state_reg     <= DONE;
                        load_done_reg <= 1'b1;
                        load_busy_reg <= 1'b0;
                     end else begin
                        samp_idx_reg <= samp_idx_reg + LAW'(1);
                        base_reg     <= base_reg + SAW'(INPUT_SIZE);
                        state_reg    <= LABEL;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sample RAM write port (contents survive reset)
   always_ff @(posedge clk) begin
      if (sample_we) sample_mem[sample_waddr] <= in_data;
   end

   // Label RAM write port; only the low nibble is kept
   always_ff @(posedge clk) begin
      if (label_we) label_mem[samp_idx_reg] <= in_data[3:0];
   end

   // Sample RAM registered read; same-cycle write returns the old word
   always_ff @(posedge clk) begin
      if (rst)            sample_rdata_reg <= '0;
      else if (sample_en) sample_rdata_reg <= sample_mem[sample_addr];
   end

   // Label RAM registered read
   always_ff @(posedge clk) begin
      if (rst)           label_rdata_reg <= '0;
      else if (label_en) label_rdata_reg <= label_mem[label_addr];
   end

endmodule

// File: tb/tb_sample_mem_loader.sv
// Directed bench for sample_mem_loader with 4 samples of 8 pixels.
module tb_sample_mem_loader;

   localparam int IS = 8;
   localparam int NS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        load_busy;
   logic        load_done;
   logic [2:0]  samples_loaded;
   logic        label_err;
   logic        frame_err;
   logic [4:0]  sample_addr = '0;
   logic        sample_en = 1'b0;
   logic [31:0] sample_rdata;
   logic [1:0]  label_addr = '0;
   logic        label_en = 1'b0;
   logic [3:0]  label_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_smp [0:IS*NS-1];
   logic [3:0]  exp_lbl [0:NS-1];

   sample_mem_loader #(
      .INPUT_SIZE (IS),
      .NUM_SAMPLES(NS),
      .DATA_WIDTH (32),
      .NUM_CLASSES(10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (load_start),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .load_busy     (load_busy),
      .load_done     (load_done),
      .samples_loaded(samples_loaded),
      .label_err     (label_err),
      .frame_err     (frame_err),
      .sample_addr   (sample_addr),
      .sample_en     (sample_en),
      .sample_rdata  (sample_rdata),
      .label_addr    (label_addr),
      .label_en      (label_en),
      .label_rdata   (label_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 32'hBAD0BAD0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
   endtask

   // One stream word; waits (bounded) for in_ready, returns 1 time unit after the transfer edge
   task automatic xfer(input logic [31:0] d, input logic l);
      int t;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      $display("xfer data=%h last=%0d", d, l);
   endtask

   // Label plus npix pixels of value pbase+k; in_last raised on pixel last_k
   task automatic send_frame(input int s, input logic [31:0] lbl, input logic [31:0] pbase,
                             input int npix, input int last_k, input bit gaps);
      if (gaps) idle($urandom_range(0, 3));
      xfer(lbl, 1'b0);
      exp_lbl[s] = lbl[3:0];
      for (int k = 0; k < npix; k++) begin
         if (gaps) idle($urandom_range(0, 3));
         xfer(pbase + k, k == last_k);
         exp_smp[s*IS+k] = pbase + k;
      end
   endtask

   task automatic rd_smp(input int a);
      sample_addr = a[4:0];
      sample_en   = 1'b1;
      @(posedge clk);
      #1 sample_en = 1'b0;
   endtask

   task automatic rd_lbl(input int a);
      label_addr = a[1:0];
      label_en   = 1'b1;
      @(posedge clk);
      #1 label_en = 1'b0;
   endtask

   task automatic verify_all(input string tag);
      for (int a = 0; a < IS*NS; a++) begin
         rd_smp(a);
         check($sformatf("%s smp[%0d]", tag, a), sample_rdata, exp_smp[a]);
      end
      for (int a = 0; a < NS; a++) begin
         rd_lbl(a);
         check($sformatf("%s lbl[%0d]", tag, a), {28'd0, label_rdata}, {28'd0, exp_lbl[a]});
      end
   endtask

   task automatic check_flags(input string tag, input int sl, input bit le, input bit fe);
      check({tag, " samples_loaded"}, {29'd0, samples_loaded}, sl);
      check({tag, " label_err"}, {31'd0, label_err}, {31'd0, le});
      check({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, fe});
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst in_ready", {31'd0, in_ready}, 32'd0);
      check("rst load_busy", {31'd0, load_busy}, 32'd0);
      check("rst load_done", {31'd0, load_done}, 32'd0);
      check_flags("rst", 0, 0, 0);
      check("rst sample_rdata", sample_rdata, 32'd0);
      check("rst label_rdata", {28'd0, label_rdata}, 32'd0);

      // Full load, in_valid held high
      pulse_start();
      check("full busy", {31'd0, load_busy}, 32'd1);
      check("full in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < NS; i++) begin
         send_frame(i, i, 32'h100 * i, IS, IS-1, 0);
         if (i == NS-2) begin
            check("full done_early", {31'd0, load_done}, 32'd0);
            check("full sl3", {29'd0, samples_loaded}, 32'd3);
         end
      end
      check("full load_done", {31'd0, load_done}, 32'd1);
      check("full busy_off", {31'd0, load_busy}, 32'd0);
      check("full ready_off", {31'd0, in_ready}, 32'd0);
      check_flags("full", 4, 0, 0);
      rd_smp(19);
      check("full smp19", sample_rdata, 32'h00000203);
      rd_lbl(2);
      check("full lbl2", {28'd0, label_rdata}, 32'd2);
      verify_all("full");

      // Words offered in DONE are ignored
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      in_last  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("done ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1 idle(1);
      in_last = 1'b0;
      check("done still", {31'd0, load_done}, 32'd1);
      verify_all("done");

      // Gapped stream with new data
      pulse_start();
      check("gap cleared", {31'd0, load_done}, 32'd0);
      for (int i = 0; i < NS; i++) send_frame(i, 9 - i, 32'hA5000000 + 32'h100 * i, IS, IS-1, 1);
      check("gap load_done", {31'd0, load_done}, 32'd1);
      check_flags("gap", 4, 0, 0);
      verify_all("gap");

      // Early in_last on pixel 4 of sample 1, then resend
      pulse_start();
      send_frame(0, 5, 32'h0E00, IS, IS-1, 0);
      check("early sl1", {29'd0, samples_loaded}, 32'd1);
      send_frame(1, 6, 32'hEEEE0000, 5, 4, 0);
      check_flags("early", 1, 0, 1);
      check("early busy", {31'd0, load_busy}, 32'd1);
      send_frame(1, 7, 32'h1100, IS, IS-1, 0);
      check("early sl2", {29'd0, samples_loaded}, 32'd2);
      send_frame(2, 8, 32'h1200, IS, IS-1, 0);
      send_frame(3, 3, 32'h1300, IS, IS-1, 0);
      check("early done", {31'd0, load_done}, 32'd1);
      check_flags("early end", 4, 0, 1);
      verify_all("early");

      // Illegal label and missing in_last
      pulse_start();
      check_flags("lerr start", 0, 0, 0);
      send_frame(0, 12, 32'h2000, IS, IS-1, 0);
      check_flags("lerr s0", 1, 1, 0);
      rd_lbl(0);
      check("lerr lbl0", {28'd0, label_rdata}, 32'hC);
      send_frame(1, 1, 32'h2100, IS, -1, 0);
      check_flags("lerr s1", 2, 1, 1);
      send_frame(2, 2, 32'h2200, IS, IS-1, 0);
      send_frame(3, 3, 32'h2300, IS, IS-1, 0);
      check("lerr done", {31'd0, load_done}, 32'd1);
      check_flags("lerr end", 4, 1, 1);

      // load_start mid sample 2 with a coincident word
      pulse_start();
      send_frame(0, 11, 32'h3000, IS, IS-1, 0);
      send_frame(1, 1, 32'h3100, IS, -1, 0);
      check_flags("rs pre", 2, 1, 1);
      send_frame(2, 2, 32'h3200, 3, -1, 0);
      in_valid   = 1'b1;
      in_data    = 32'h00000077;
      load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
      in_valid = 1'b0;
      check_flags("rs post", 0, 0, 0);
      check("rs busy", {31'd0, load_busy}, 32'd1);
      send_frame(0, 13, 32'hABC0, IS, IS-1, 0);
      check("rs sl1", {29'd0, samples_loaded}, 32'd1);
      rd_lbl(0);
      check("rs lbl0", {28'd0, label_rdata}, 32'hD);
      rd_smp(0);
      check("rs smp0", sample_rdata, 32'hABC0);
      rd_smp(19);
      check("rs smp19", sample_rdata, exp_smp[19]);

      // rst during PIXEL
      send_frame(1, 1, 32'hD100, 2, -1, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst in_ready", {31'd0, in_ready}, 32'd0);
      check("mrst busy", {31'd0, load_busy}, 32'd0);
      check("mrst done", {31'd0, load_done}, 32'd0);
      check_flags("mrst", 0, 0, 0);
      check("mrst sample_rdata", sample_rdata, 32'd0);
      check("mrst label_rdata", {28'd0, label_rdata}, 32'd0);
      rst = 1'b0;
      verify_all("mrst");

      // Read/write collision on address 5
      pulse_start();
      xfer(32'd0, 1'b0);
      exp_lbl[0] = 4'd0;
      for (int k = 0; k < 5; k++) begin
         xfer(32'hC0110000 + k, 1'b0);
         exp_smp[k] = 32'hC0110000 + k;
      end
      in_data     = 32'hC0110005;
      in_last     = 1'b0;
      in_valid    = 1'b1;
      sample_addr = 5'd5;
      sample_en   = 1'b1;
      check("coll ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      sample_en = 1'b0;
      $display("xfer data=%h last=0 (with read of addr 5)", in_data);
      check("coll old", sample_rdata, exp_smp[5]);
      exp_smp[5] = 32'hC0110005;
      rd_smp(5);
      check("coll new", sample_rdata, 32'hC0110005);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
